// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline definitions for the IF/ID stage register.
//   NOP_INSTR_DEF : default bubble instruction (sll $0,$0,0).
//   if_id_t       : {pc, instr} entry layout at default widths.
//                   The stage packs its payload in this same order.
//   skid_state_e  : occupancy of the 2-entry skid buffer.
package mips_pipe_pkg;

   localparam int PC_W_DEF    = 32;
   localparam int INSTR_W_DEF = 32;

   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

   typedef struct packed {
      logic [PC_W_DEF-1:0]    pc;
      logic [INSTR_W_DEF-1:0] instr;
   } if_id_t;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      FULL  = 2'b10
   } skid_state_e;

endpackage

// File: rtl/if_id_skid_reg_if.sv
// Handshake bundle between fetch, the IF/ID stage and decode.
//   flush                         : squash request (into the stage)
//   in_valid/in_ready/in_pc/in_instr     : fetch side
//   out_valid/out_ready/out_pc/out_instr : decode side
// Modports:
//   slave  : view taken by the stage register.
//   master : view taken by whatever drives the stage (fetch/decode or a bench).
interface if_id_skid_reg_if #(
   parameter int PC_W    = 32,
   parameter int INSTR_W = 32
);
   logic               flush;
   logic               in_valid;
   logic               in_ready;
   logic [PC_W-1:0]    in_pc;
   logic [INSTR_W-1:0] in_instr;
   logic               out_valid;
   logic               out_ready;
   logic [PC_W-1:0]    out_pc;
   logic [INSTR_W-1:0] out_instr;

   modport slave (
      input  flush, in_valid, in_pc, in_instr, out_ready,
      output in_ready, out_valid, out_pc, out_instr
   );

   modport master (
      output flush, in_valid, in_pc, in_instr, out_ready,
      input  in_ready, out_valid, out_pc, out_instr
   );
endinterface

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry skid buffer over a DATA_W payload.
// in_ready is a flop, so it never depends combinationally on out_ready.
// Ports:
//   clk, rst        : clock, async active-high reset
//   clr             : synchronous clear; empties buffer, main <= CLR_DATA
//   in_valid/in_ready/in_data    : upstream handshake
//   out_valid/out_ready/out_data : downstream handshake (out_data = main)
//
// state | meaning
// EMPTY | nothing held
// ONE   | main slot valid
// FULL  | main + skid valid, upstream stalled
module pipe_skid_buf
   import mips_pipe_pkg::*;
#(
   parameter int                DATA_W   = 64,
   parameter logic [DATA_W-1:0] CLR_DATA = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
);

   skid_state_e       state, state_nxt;
   logic [DATA_W-1:0] main_q, main_nxt;
   logic [DATA_W-1:0] skid_q, skid_nxt;
   logic              in_ready_q;
   logic              xfer_in, xfer_out;

   assign in_ready  = in_ready_q;
   assign out_valid = (state != EMPTY);
   assign out_data  = main_q;
   assign xfer_in   = in_valid && in_ready_q;
   assign xfer_out  = out_valid && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= EMPTY;
         in_ready_q <= 1'b1;
         main_q     <= CLR_DATA;
         skid_q     <= '0;
      end else begin
         state      <= state_nxt;
         in_ready_q <= (state_nxt != FULL);
         main_q     <= main_nxt;
         skid_q     <= skid_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      main_nxt  = main_q;
      skid_nxt  = skid_q;
      if (clr) begin
         // Any input beat this cycle is dropped; skid contents are dead.
         state_nxt = EMPTY;
         main_nxt  = CLR_DATA;
      end else begin
         case (state)
            EMPTY: begin
               if (xfer_in) begin
                  state_nxt = ONE;
                  main_nxt  = in_data;
               end
            end
            ONE: begin
               if (xfer_in && xfer_out) begin
                  main_nxt = in_data;
               end else if (xfer_in) begin
                  state_nxt = FULL;
                  skid_nxt  = in_data;
               end else if (xfer_out) begin
                  state_nxt = EMPTY;
               end
            end
            FULL: begin
               if (xfer_out) begin
                  state_nxt = ONE;
                  main_nxt  = skid_q;
               end
            end
            default: state_nxt = EMPTY;
         endcase
      end
   end

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline stage register with valid/ready on both sides, built on a
// 2-entry skid buffer. Flush empties the stage and leaves a NOP bubble
// (pc=0, instr=NOP_INSTR) on the decode side.
// Ports:
//   clk, rst  : clock, async active-high reset
//   bus       : if_id_skid_reg_if.slave (flush, fetch and decode handshakes)
//   stall_cnt : cycles with out_valid && !out_ready (IF_ID_SKID_PERF_EN only)
//   flush_cnt : cycles with flush asserted        (IF_ID_SKID_PERF_EN only)
// Define IF_ID_SKID_PERF_EN to add the saturating perf counters.
module if_id_skid_reg
   import mips_pipe_pkg::*;
#(
   parameter int                 PC_W      = 32,
   parameter int                 INSTR_W   = 32,
   parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF)
) (
   input  logic                  clk,
   input  logic                  rst,
   if_id_skid_reg_if.slave       bus
`ifdef IF_ID_SKID_PERF_EN
   ,
   output logic [31:0]           stall_cnt,
   output logic [31:0]           flush_cnt
`endif
);

   localparam int                DATA_W    = PC_W + INSTR_W;
   localparam logic [DATA_W-1:0] NOP_ENTRY = {{PC_W{1'b0}}, NOP_INSTR};

   logic [DATA_W-1:0] out_data;

   pipe_skid_buf #(
      .DATA_W   (DATA_W),
      .CLR_DATA (NOP_ENTRY)
   ) u_buf (
      .clk       (clk),
      .rst       (rst),
      .clr       (bus.flush),
      .in_valid  (bus.in_valid),
      .in_ready  (bus.in_ready),
      .in_data   ({bus.in_pc, bus.in_instr}),
      .out_valid (bus.out_valid),
      .out_ready (bus.out_ready),
      .out_data  (out_data)
   );

   assign bus.out_pc    = out_data[DATA_W-1:INSTR_W];
   assign bus.out_instr = out_data[INSTR_W-1:0];

`ifdef IF_ID_SKID_PERF_EN
   // Saturating; flush does not clear them, only rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (bus.out_valid && !bus.out_ready && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 32'd1;
         if (bus.flush && (flush_cnt != '1))
            flush_cnt <= flush_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
module tb_if_id_skid_reg;
   localparam int PC_W    = 32;
   localparam int INSTR_W = 32;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   if_id_skid_reg_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

`ifdef IF_ID_SKID_PERF_EN
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;
`endif

   if_id_skid_reg #(
      .PC_W      (PC_W),
      .INSTR_W   (INSTR_W),
      .NOP_INSTR (32'h0000_0000)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus)
`ifdef IF_ID_SKID_PERF_EN
      ,
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins);
      bus.in_valid = v;
      bus.in_pc    = pc;
      bus.in_instr = ins;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;
      drive(1'b0, 32'h0, 32'h0);

      #12;
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
      chk("rst_out_pc",    64'(bus.out_pc),    64'd0);
      chk("rst_out_instr", 64'(bus.out_instr), 64'h0);
      rst = 1'b0;
      step();

      // Stream at full rate
      bus.out_ready = 1'b1;
      drive(1'b1, 32'h0, 32'h2008_0001);
      chk("pre_accept_out_valid", 64'(bus.out_valid), 64'd0);
      step();
      chk("s0_out_valid", 64'(bus.out_valid), 64'd1);
      chk("s0_out_pc",    64'(bus.out_pc),    64'h0);
      chk("s0_out_instr", 64'(bus.out_instr), 64'h2008_0001);
      drive(1'b1, 32'h4, 32'h2008_0002);
      step();
      chk("s1_out_pc",    64'(bus.out_pc),    64'h4);
      chk("s1_out_instr", 64'(bus.out_instr), 64'h2008_0002);
      chk("s1_in_ready",  64'(bus.in_ready),  64'd1);
      drive(1'b1, 32'h8, 32'h2008_0003);
      step();
      chk("s2_out_pc",    64'(bus.out_pc),    64'h8);
      drive(1'b1, 32'hC, 32'h2008_0004);
      step();
      chk("s3_out_pc",    64'(bus.out_pc),    64'hC);
      chk("s3_out_instr", 64'(bus.out_instr), 64'h2008_0004);
      chk("s3_in_ready",  64'(bus.in_ready),  64'd1);
      drive(1'b0, 32'h0, 32'h0);
      step();
      chk("drain_out_valid", 64'(bus.out_valid), 64'd0);
      chk("drain_hold_pc",   64'(bus.out_pc),    64'hC);

      // Backpressure fill
      bus.out_ready = 1'b0;
      drive(1'b1, 32'h10, 32'h2008_0010);
      step();
      chk("bp0_out_pc",   64'(bus.out_pc),   64'h10);
      chk("bp0_in_ready", 64'(bus.in_ready), 64'd1);
      drive(1'b1, 32'h14, 32'h2008_0014);
      step();
      chk("bp1_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp1_out_pc",   64'(bus.out_pc),   64'h10);
      drive(1'b1, 32'h18, 32'h2008_0018);
      step();
      chk("bp2_in_ready",  64'(bus.in_ready),  64'd0);
      chk("bp2_out_pc",    64'(bus.out_pc),    64'h10);
      chk("bp2_out_instr", 64'(bus.out_instr), 64'h2008_0010);

      // Release from FULL; 0x18 stays presented until taken
      bus.out_ready = 1'b1;
      step();
      chk("rel0_out_pc",   64'(bus.out_pc),   64'h14);
      chk("rel0_in_ready", 64'(bus.in_ready), 64'd1);
      step();
      chk("rel1_out_pc",    64'(bus.out_pc),    64'h18);
      chk("rel1_out_instr", 64'(bus.out_instr), 64'h2008_0018);
      drive(1'b0, 32'h0, 32'h0);
      step();
      chk("rel2_out_valid", 64'(bus.out_valid), 64'd0);

      // Flush while FULL with a concurrent input beat
      bus.out_ready = 1'b0;
      drive(1'b1, 32'h20, 32'h2008_0020);
      step();
      drive(1'b1, 32'h24, 32'h2008_0024);
      step();
      chk("fl_pre_in_ready", 64'(bus.in_ready), 64'd0);
      bus.flush = 1'b1;
      drive(1'b1, 32'h40, 32'h2008_0040);
      step();
      bus.flush = 1'b0;
      chk("fl_out_valid", 64'(bus.out_valid), 64'd0);
      chk("fl_out_pc",    64'(bus.out_pc),    64'h0);
      chk("fl_out_instr", 64'(bus.out_instr), 64'h0);
      chk("fl_in_ready",  64'(bus.in_ready),  64'd1);
      drive(1'b0, 32'h0, 32'h0);
      step();
      chk("fl_no_0x40_valid", 64'(bus.out_valid), 64'd0);
      chk("fl_no_0x40_pc",    64'(bus.out_pc),    64'h0);

      // Async reset mid-stall while FULL
      drive(1'b1, 32'h30, 32'h2008_0030);
      step();
      drive(1'b1, 32'h34, 32'h2008_0034);
      step();
      drive(1'b0, 32'h0, 32'h0);
      chk("ar_pre_in_ready", 64'(bus.in_ready), 64'd0);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_out_valid", 64'(bus.out_valid), 64'd0);
      chk("ar_in_ready",  64'(bus.in_ready),  64'd1);
      chk("ar_out_pc",    64'(bus.out_pc),    64'h0);
      rst = 1'b0;
      step();

`ifdef IF_ID_SKID_PERF_EN
      chk("perf_rst_stall", 64'(stall_cnt), 64'd0);
      chk("perf_rst_flush", 64'(flush_cnt), 64'd0);
      bus.out_ready = 1'b0;
      drive(1'b1, 32'h50, 32'h2008_0050);
      step();
      drive(1'b0, 32'h0, 32'h0);
      repeat (5) step();
      chk("perf_stall5", 64'(stall_cnt), 64'd5);
      bus.out_ready = 1'b1;
      bus.flush     = 1'b1;
      repeat (2) step();
      bus.flush = 1'b0;
      chk("perf_flush2", 64'(flush_cnt), 64'd2);
      chk("perf_stall_kept", 64'(stall_cnt), 64'd5);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/if_id_skid_reg.md
Name: if_id_skid_reg

Overview:
- Parametrised IF/ID pipeline stage register with a valid/ready handshake on both sides.
- Uses a 2-entry skid buffer, so in_ready comes straight from a flop and never combinationally from out_ready, with no loss of throughput.
- Supports a synchronous flush for branch/jump squash; flush injects a bubble carrying the NOP encoding.
- Sits between the fetch stage (PC + imem) and decode; replaces the plain always-load stage register.

Parameters:
- PC_W, 32, width of the PC field.
- INSTR_W, 32, width of the instruction field.
- NOP_INSTR, 32'h0000_0000, instruction value driven on reset and on flush (sll $0,$0,0).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- flush  in  1  synchronous squash of every held entry; highest priority.
- in_valid  in  1  fetch presents a valid pc/instr pair.
- in_ready  out  1  stage can accept a pair this cycle; registered.
- in_pc  in  PC_W  fetched PC (PC+4 convention is set by fetch, not by this block).
- in_instr  in  INSTR_W  fetched instruction.
- out_valid  out  1  decode-side entry valid.
- out_ready  in  1  decode accepts this cycle (low = stall).
- out_pc  out  PC_W  head entry PC.
- out_instr  out  INSTR_W  head entry instruction.

Behaviour:
- Handshakes:
  - Input transfer: in_valid && in_ready.
  - Output transfer: out_valid && out_ready.
  - in_valid may rise or fall freely; nothing is accepted unless in_ready=1.
- Storage:
  - main slot drives out_* directly.
  - skid slot holds the overflow entry.
- State, 2-bit: EMPTY (none), ONE (main valid), FULL (main + skid valid).
- Derived outputs:
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL), registered with the state.
- Transitions when flush=0 (xfer_in = input transfer, xfer_out = output transfer):
  - EMPTY: xfer_in -> ONE, main <= in.
  - ONE: xfer_in & xfer_out -> ONE, main <= in. xfer_in only -> FULL, skid <= in. xfer_out only -> EMPTY.
  - FULL: xfer_out -> ONE, main <= skid. in_ready=0, so no input is accepted.
- Latency and throughput:
  - Input accepted at edge N appears on out_* after edge N, i.e. one cycle.
  - Sustains 1 transfer/cycle while out_ready=1.
- Data hold:
  - When the stage drains to EMPTY, main data is held unchanged.
  - out_* are stable whenever out_valid=1 && out_ready=0.
- Flush, when flush=1 at an edge:
  - state <= EMPTY.
  - main.pc <= 0, main.instr <= NOP_INSTR.
  - skid is discarded.
  - A concurrent input transfer is dropped; in_ready still reads 1 if the prior state was not FULL, and fetch treats that beat as squashed.
  - Any concurrent output transfer does happen; decode owns squashing it.
- Reset:
  - state=EMPTY, in_ready=1, out_valid=0, out_pc=0, out_instr=NOP_INSTR, skid=0.
  - Applies asynchronously, including mid-stall or while FULL.
- Width rules: fields are copied verbatim, with no arithmetic on pc/instr.
- Illegal states: the unused 2-bit encoding recovers to EMPTY.

Optional Feature:
- Macro: IF_ID_SKID_PERF_EN.
- With the macro defined, two extra output ports are added:
  - stall_cnt [31:0]: increments each cycle out_valid && !out_ready.
  - flush_cnt [31:0]: increments each cycle flush=1.
  - Both saturate at all-ones, clear on rst, and are never cleared by flush.
- Without the macro, neither the ports nor the counter logic exist; the interface is exactly the Ports list above.

Decomposition:
- Shared package mips_pipe_pkg holds:
  - localparam NOP_INSTR_DEF = 32'h0000_0000.
  - typedef if_id_t {pc, instr}.
  - The state enum {EMPTY, ONE, FULL}.
- A single natural sub-module, pipe_skid_buf, is the generic 2-entry handshake buffer over a DATA_W payload. if_id_skid_reg wraps it, adds the flush/NOP injection, and houses the perf counters.

Test Plan:
- Reset then stream:
  - Stimulus: rst pulse; then in_valid=1 with pc 0x0,0x4,0x8,0xC and instr 0x20080001.., out_ready=1.
  - Response: out_valid rises 1 cycle after the first accept; out_pc 0x0,0x4,0x8,0xC on consecutive cycles; in_ready stays 1.
- Backpressure fill:
  - Stimulus: out_ready=0 while feeding pc 0x10 then 0x14.
  - Response: state FULL, in_ready=0, out_pc holds 0x10; 0x18 is not accepted.
- Release from FULL:
  - Stimulus: raise out_ready.
  - Response: out_pc 0x10 then 0x14 then 0x18; in_ready returns to 1 one cycle after the first drain; no entry is lost or duplicated.
- Flush while FULL with concurrent in_valid:
  - Stimulus: FULL state, flush=1, in_valid=1, pc 0x40.
  - Response: next cycle out_valid=0, out_pc=0, out_instr=0x00000000, in_ready=1; 0x40 never appears.
- Async reset mid-stall:
  - Stimulus: assert rst between edges while FULL.
  - Response: out_valid=0 and in_ready=1 immediately, without waiting for a clk edge.
- Perf (IF_ID_SKID_PERF_EN):
  - Stimulus: 5 stalled cycles plus 2 flush cycles.
  - Response: stall_cnt=5, flush_cnt=2.
  - Stimulus: preload 0xFFFFFFFF and stall further.
  - Response: counters hold at 0xFFFFFFFF.
